// File: rtl/sequence_tx_generator.sv
// rtl/sequence_tx_generator.sv - serial pattern transmitter, MSB-first, with repeats and idle gaps
// Shifts a captured pattern word out one bit per clock for a programmable number of passes.
module sequence_tx_generator #(
  parameter int MAX_LEN    = 16,
  parameter int CNT_W      = 5,
  parameter int REP_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [CNT_W-1:0]   length_in,
  input  logic [REP_W-1:0]   repeat_in,
  input  logic               idle_level,
  output logic               sequence_out,
  output logic               bit_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W:0] MAX_LEN_C = (CNT_W+1)'(MAX_LEN);
  localparam logic [7:0]     GAP_LAST  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [7:0]         gap_q, gap_d;
  logic               idle_q, idle_d;
  logic               seq_q, seq_d;
  logic               bv_q, bv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               len_ok;
  logic [IDX_W-1:0]   len_last;

  assign len_ok   = (length_in != '0) && ({1'b0, length_in} <= MAX_LEN_C);
  assign len_last = IDX_W'(length_in - 1'b1);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    last_d  = last_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    idle_d  = idle_q;
    seq_d   = seq_q;
    bv_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        seq_d = idle_level;
        if (start) begin
          if (len_ok) begin
            state_d = S_SHIFT;
            pat_d   = pattern_in;
            last_d  = len_last;
            idx_d   = len_last;
            rep_d   = repeat_in;
            idle_d  = idle_level;
            seq_d   = pattern_in[len_last];
            bv_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
          seq_d = pat_q[idx_q - 1'b1];
          bv_d  = 1'b1;
        end else if (rep_q != '0) begin
          rep_d = rep_q - 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LAST;
            seq_d   = idle_q;
          end else begin
            idx_d = last_q;
            seq_d = pat_q[last_q];
            bv_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
          seq_d   = idle_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        seq_d  = idle_q;
        // gap_q holds the number of gap cycles still to go after this one
        if (gap_q == '0) begin
          state_d = S_SHIFT;
          idx_d   = last_q;
          seq_d   = pat_q[last_q];
          bv_d    = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      idle_q  <= 1'b0;
      seq_q   <= 1'b0;
      bv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      idle_q  <= idle_d;
      seq_q   <= seq_d;
      bv_q    <= bv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sequence_out = seq_q;
  assign bit_valid    = bv_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule
